// File: rtl/coffee_brew_controller.sv
// Brew-cycle controller: debounces Brew/Refill, tracks reservoir cups and
// sequences IDLE -> BREWING -> DONE -> (IDLE | NEED_WATER).
module coffee_brew_controller #(
    parameter int unsigned BREW_CYCLES     = 300_000_000,
    parameter int unsigned DONE_CYCLES     = 200_000_000,
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic       clk_100MHz,
    input  logic       reset_n,
    input  logic       btn_brew,
    input  logic       btn_refill,
    output logic [1:0] state,
    output logic [1:0] cup_count,
    output logic       brewing_led
);

    localparam int unsigned BREW_W = ($clog2(BREW_CYCLES) > 0) ? $clog2(BREW_CYCLES) : 1;
    localparam int unsigned DONE_W = ($clog2(DONE_CYCLES) > 0) ? $clog2(DONE_CYCLES) : 1;
    localparam int unsigned DB_W   = ($clog2(DEBOUNCE_CYCLES) > 0) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned NBTN   = 2;
    localparam int unsigned BTN_BREW   = 0;
    localparam int unsigned BTN_REFILL = 1;

    localparam logic [BREW_W-1:0] BREW_LAST = BREW_W'(BREW_CYCLES - 1);
    localparam logic [DONE_W-1:0] DONE_LAST = DONE_W'(DONE_CYCLES - 1);
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [1:0]        CUPS_FULL = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'b00,
        ST_BREWING    = 2'b01,
        ST_DONE       = 2'b10,
        ST_NEED_WATER = 2'b11
    } state_t;

    logic [NBTN-1:0]           r_sync0;
    logic [NBTN-1:0]           r_sync1;
    logic [NBTN-1:0]           r_db;
    logic [NBTN-1:0]           r_db_d;
    logic [NBTN-1:0]           r_pulse;
    logic [NBTN-1:0][DB_W-1:0] r_db_cnt;

    state_t            r_state;
    logic [1:0]        r_cups;
    logic              r_led;
    logic [BREW_W-1:0] r_brew_tmr;
    logic [DONE_W-1:0] r_done_tmr;

    logic w_brew_pulse;
    logic w_refill_pulse;

    // Per-button 2-FF synchronizer, level debounce and registered rising-edge pulse
    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            r_sync0  <= '0;
            r_sync1  <= '0;
            r_db     <= '0;
            r_db_d   <= '0;
            r_pulse  <= '0;
            r_db_cnt <= '0;
        end else begin
            r_sync0 <= {btn_refill, btn_brew};
            r_sync1 <= r_sync0;
            for (int i = 0; i < int'(NBTN); i++) begin
                if (r_sync1[i] == r_db[i]) begin
                    r_db_cnt[i] <= '0;
                end else if (r_db_cnt[i] == DB_LAST) begin
                    r_db[i]     <= r_sync1[i];
                    r_db_cnt[i] <= '0;
                end else begin
                    r_db_cnt[i] <= r_db_cnt[i] + DB_W'(1);
                end
            end
            r_db_d  <= r_db;
            r_pulse <= r_db & ~r_db_d;
        end
    end

    assign w_brew_pulse   = r_pulse[BTN_BREW];
    assign w_refill_pulse = r_pulse[BTN_REFILL];

    // Machine sequencing; brewing_led is registered alongside the state it decodes
    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_cups     <= CUPS_FULL;
            r_led      <= 1'b0;
            r_brew_tmr <= '0;
            r_done_tmr <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // Brew takes priority; a simultaneous Refill is dropped
                    if (w_brew_pulse && (r_cups != 2'd0)) begin
                        r_state    <= ST_BREWING;
                        r_brew_tmr <= '0;
                        r_led      <= 1'b1;
                    end else if (w_refill_pulse) begin
                        r_cups <= CUPS_FULL;
                    end
                end
                ST_BREWING: begin
                    if (r_brew_tmr == BREW_LAST) begin
                        r_state    <= ST_DONE;
                        r_cups     <= r_cups - 2'd1;
                        r_brew_tmr <= '0;
                        r_done_tmr <= '0;
                        r_led      <= 1'b0;
                    end else begin
                        r_brew_tmr <= r_brew_tmr + BREW_W'(1);
                    end
                end
                ST_DONE: begin
                    if (r_done_tmr == DONE_LAST) begin
                        r_done_tmr <= '0;
                        r_state    <= (r_cups == 2'd0) ? ST_NEED_WATER : ST_IDLE;
                    end else begin
                        r_done_tmr <= r_done_tmr + DONE_W'(1);
                    end
                end
                ST_NEED_WATER: begin
                    if (w_refill_pulse) begin
                        r_cups  <= CUPS_FULL;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_led   <= 1'b0;
                end
            endcase
        end
    end

    assign state       = r_state;
    assign cup_count   = r_cups;
    assign brewing_led = r_led;

endmodule

// File: tb/tb_coffee_brew_controller.sv
// Directed bench for coffee_brew_controller: expected state segments are queued
// as buttons are pressed and checked against the observed state sequence.
module tb_coffee_brew_controller;

    logic       clk_100MHz = 1'b0;
    logic       reset_n;
    logic       btn_brew;
    logic       btn_refill;
    logic [1:0] state;
    logic [1:0] cup_count;
    logic       brewing_led;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [1:0] st;
        logic [1:0] cup;
        int         len;
    } seg_t;

    seg_t sb_q[$];

    coffee_brew_controller #(
        .BREW_CYCLES    (10),
        .DONE_CYCLES    (5),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk_100MHz (clk_100MHz),
        .reset_n    (reset_n),
        .btn_brew   (btn_brew),
        .btn_refill (btn_refill),
        .state      (state),
        .cup_count  (cup_count),
        .brewing_led(brewing_led)
    );

    always #5 clk_100MHz = ~clk_100MHz;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic push(input logic [1:0] st, input logic [1:0] cup, input int len);
        seg_t s;
        s.st  = st;
        s.cup = cup;
        s.len = len;
        sb_q.push_back(s);
    endtask

    // which: 0 = Brew, 1 = Refill, 2 = both
    task automatic press(input int which, input int hold);
        if (which != 1) btn_brew = 1'b1;
        if (which != 0) btn_refill = 1'b1;
        repeat (hold) @(negedge clk_100MHz);
        if (which != 1) btn_brew = 1'b0;
        if (which != 0) btn_refill = 1'b0;
    endtask

    task automatic wait_state(input string tag, input logic [1:0] s, input int bound);
        int n = 0;
        while ((state !== s) && (n < bound)) begin
            @(negedge clk_100MHz);
            n++;
        end
        chk({tag, "_reached"}, 32'(state === s), 32'd1);
    endtask

    task automatic check_seg(input string tag, input seg_t e);
        chk({tag, "_state"}, 32'(state), 32'(e.st));
        chk({tag, "_cups"}, 32'(cup_count), 32'(e.cup));
        chk({tag, "_led"}, 32'(brewing_led), 32'(e.st == 2'b01));
        if (e.len > 0) begin
            int k = 1;
            while (k < e.len + 5) begin
                @(negedge clk_100MHz);
                if (state !== e.st) break;
                k++;
            end
            chk({tag, "_len"}, 32'(k), 32'(e.len));
        end
    endtask

    task automatic run_segs(input string tag);
        seg_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_seg(tag, e);
        end
    endtask

    task automatic settle(input string tag, input logic [1:0] st, input logic [1:0] cup, input int n);
        repeat (n) @(negedge clk_100MHz);
        chk({tag, "_state"}, 32'(state), 32'(st));
        chk({tag, "_cups"}, 32'(cup_count), 32'(cup));
    endtask

    // Reset asserted mid-cycle must take effect before the next clock edge
    task automatic async_reset(input string tag);
        @(posedge clk_100MHz);
        #2 reset_n = 1'b0;
        #1;
        chk({tag, "_state"}, 32'(state), 32'd0);
        chk({tag, "_cups"}, 32'(cup_count), 32'd3);
        chk({tag, "_led"}, 32'(brewing_led), 32'd0);
        @(negedge clk_100MHz);
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n    = 1'b0;
        btn_brew   = 1'b0;
        btn_refill = 1'b0;
        repeat (3) @(negedge clk_100MHz);
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_cups", 32'(cup_count), 32'd3);
        chk("rst_led", 32'(brewing_led), 32'd0);
        reset_n = 1'b1;
        settle("rst_release", 2'd0, 2'd3, 2);

        // Long single press: one brew, one pulse
        push(2'd1, 2'd3, 10);
        push(2'd2, 2'd2, 5);
        push(2'd0, 2'd2, 0);
        fork press(0, 20); join_none
        wait_state("t2", 2'd1, 40);
        run_segs("t2");
        settle("t2_onepulse", 2'd0, 2'd2, 12);

        // Drain the reservoir from reset
        async_reset("t3_rst");
        for (int i = 0; i < 3; i++) begin
            push(2'd1, 2'(3 - i), 10);
            push(2'd2, 2'(2 - i), 5);
            push((i == 2) ? 2'd3 : 2'd0, 2'(2 - i), 0);
            fork press(0, 5); join_none
            wait_state("t3_brew", 2'd1, 40);
            run_segs("t3_brew");
            repeat (10) @(negedge clk_100MHz);
        end
        press(0, 6);
        settle("t3_nw_brew", 2'd3, 2'd0, 10);
        push(2'd0, 2'd3, 0);
        fork press(1, 6); join_none
        wait_state("t3_refill", 2'd0, 40);
        run_segs("t3_refill");
        repeat (10) @(negedge clk_100MHz);

        // Glitchy Brew: short highs never survive debounce
        for (int i = 0; i < 3; i++) begin
            btn_brew = 1'b1;
            @(negedge clk_100MHz);
            btn_brew = 1'b0;
            @(negedge clk_100MHz);
        end
        begin
            int nz = 0;
            repeat (15) begin
                @(negedge clk_100MHz);
                if (state !== 2'd0) nz++;
            end
            chk("t4_glitch_nonidle", 32'(nz), 32'd0);
        end

        // Refill during BREWING, Brew during DONE: both ignored
        push(2'd1, 2'd3, 10);
        push(2'd2, 2'd2, 5);
        push(2'd0, 2'd2, 0);
        fork press(0, 5); join_none
        wait_state("t5a", 2'd1, 40);
        fork
            press(1, 5);
            begin
                repeat (4) @(negedge clk_100MHz);
                press(0, 5);
            end
        join_none
        run_segs("t5a");
        settle("t5a_after", 2'd0, 2'd2, 12);

        // Reset during BREWING aborts without decrement
        fork press(0, 5); join_none
        wait_state("t6_start", 2'd1, 40);
        repeat (5) @(negedge clk_100MHz);
        async_reset("t6_abort");
        settle("t6_idle", 2'd0, 2'd3, 8);
        push(2'd1, 2'd3, 10);
        push(2'd2, 2'd2, 5);
        push(2'd0, 2'd2, 0);
        fork press(0, 5); join_none
        wait_state("t6_rebrew", 2'd1, 40);
        run_segs("t6_rebrew");
        repeat (10) @(negedge clk_100MHz);

        // Brew and Refill together in IDLE: Brew wins
        push(2'd1, 2'd2, 10);
        push(2'd2, 2'd1, 5);
        push(2'd0, 2'd1, 0);
        fork press(2, 5); join_none
        wait_state("t4_both", 2'd1, 40);
        run_segs("t4_both");
        repeat (10) @(negedge clk_100MHz);

        // Both buttons during DONE on the last cup: still lands in NEED_WATER
        push(2'd1, 2'd1, 10);
        push(2'd2, 2'd0, 5);
        push(2'd3, 2'd0, 0);
        fork press(0, 5); join_none
        wait_state("t5b", 2'd1, 40);
        fork
            begin
                repeat (4) @(negedge clk_100MHz);
                press(2, 5);
            end
        join_none
        run_segs("t5b");
        settle("t5b_nw", 2'd3, 2'd0, 12);
        push(2'd0, 2'd3, 0);
        fork press(1, 6); join_none
        wait_state("t5b_refill", 2'd0, 40);
        run_segs("t5b_refill");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
